// File: rtl/lsu_vec.sv
// lsu_vec: multi-lane load/store unit. Captures one vector load or store,
// then walks the active lanes lowest-first through a single memory port,
// one outstanding request at a time.
module lsu_vec #(
   parameter int NUM_LANES       = 4,
   parameter int DATA_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH      = 16,
   parameter int LANE_IDX_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [3:0]                      cu_state,
   input  logic                            lsu_en,
   input  logic                            mem_ren,
   input  logic                            mem_wen,
   input  logic [NUM_LANES-1:0]            lane_mask,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] rs1,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] rs2,
   output logic [NUM_LANES*DATA_WIDTH-1:0] lsu_data_out,
   output logic [1:0]                      lsu_state,
   output logic                            req_val,
   input  logic                            req_rdy,
   output logic                            req_we,
   output logic [DATA_ADDR_WIDTH-1:0]      req_addr,
   output logic [DATA_WIDTH-1:0]           req_data,
   output logic [LANE_IDX_W-1:0]           req_lane,
   input  logic                            resp_val,
   output logic                            resp_rdy,
   input  logic [DATA_WIDTH-1:0]           resp_data
);

   localparam logic [3:0] CU_REQ = 4'd3;
   localparam logic [3:0] CU_WB  = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                          state_q, state_d;
   logic [NUM_LANES-1:0]            pend_q, pend_d;
   logic                            op_st_q, op_st_d;
   logic [NUM_LANES*DATA_WIDTH-1:0] rs1_q, rs1_d;
   logic [NUM_LANES*DATA_WIDTH-1:0] rs2_q, rs2_d;
   logic [NUM_LANES*DATA_WIDTH-1:0] dout_q, dout_d;
   logic [LANE_IDX_W-1:0]           lane;
   logic [NUM_LANES-1:0]            lane_bit;
   logic                            unused_rs2_bits;

   // Current lane: lowest set bit of the pending mask
   always_comb begin
      lane = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pend_q[i]) lane = LANE_IDX_W'(i);
      end
   end

   assign lane_bit = NUM_LANES'(1) << lane;

   // Only the low address bits of each captured rs2 lane reach the port
   assign unused_rs2_bits = ^rs2_q;

   // Next-state, operand capture and load write-back
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      op_st_d = op_st_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      dout_d  = dout_q;
      case (state_q)
         S_IDLE: begin
            if (lsu_en && (cu_state == CU_REQ) && (mem_ren || mem_wen)) begin
               rs1_d   = rs1;
               rs2_d   = rs2;
               op_st_d = !mem_ren;   // load wins when both are set
               pend_d  = lane_mask;
               state_d = (lane_mask == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (req_rdy) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (resp_val) begin
               if (!op_st_q) dout_d[int'(lane)*DATA_WIDTH +: DATA_WIDTH] = resp_data;
               pend_d  = pend_q & ~lane_bit;
               state_d = ((pend_q & ~lane_bit) == '0) ? S_DONE : S_REQ;
            end
         end
         S_DONE: begin
            if (cu_state == CU_WB) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and operand registers; reset clears everything so outputs read 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pend_q  <= '0;
         op_st_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         op_st_q <= op_st_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         dout_q  <= dout_d;
      end
   end

   // Outputs decoded from registered state and captured operands only
   assign lsu_state    = state_q;
   assign req_val      = (state_q == S_REQ);
   assign resp_rdy     = (state_q == S_WAIT);
   assign req_we       = op_st_q;
   assign req_lane     = lane;
   assign req_addr     = rs2_q[int'(lane)*DATA_WIDTH +: DATA_ADDR_WIDTH];
   assign req_data     = rs1_q[int'(lane)*DATA_WIDTH +: DATA_WIDTH];
   assign lsu_data_out = dout_q;

endmodule

// File: tb/tb_lsu_vec.sv
// Testbench for lsu_vec: directed table, reset-abort sequence and random
// operations against a lane-level reference model and a memory responder.
module tb_lsu_vec;
   localparam int NL = 4;
   localparam int AW = 8;
   localparam int DW = 16;
   localparam int LW = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       cu_state;
   logic             lsu_en, mem_ren, mem_wen;
   logic [NL-1:0]    lane_mask;
   logic [NL*DW-1:0] rs1, rs2, lsu_data_out;
   logic [1:0]       lsu_state;
   logic             req_val, req_rdy, req_we;
   logic [AW-1:0]    req_addr;
   logic [DW-1:0]    req_data;
   logic [LW-1:0]    req_lane;
   logic             resp_val, resp_rdy;
   logic [DW-1:0]    resp_data;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]    mem     [256];   // memory seen by the responder
   logic [DW-1:0]    ref_mem [256];   // reference model memory
   logic [NL*DW-1:0] exp_dout;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [3:0]  mask;
      logic [63:0] r1;
      logic [63:0] r2;
      int          rdy_d;     // cycles req_rdy held low; <0 = random
      int          resp_d;    // cycles before resp_val; <0 = random
      int          spur;      // spurious resp_val pulses in REQ
      int          exp_nreq;
      logic        exp_we;
      int          exp_cyc;   // start-to-DONE cycles; <=0 = not checked
   } vec_t;

   vec_t tbl [6];
   vec_t rv;
   int   cyc, nreq;
   logic lw;

   always #5 clk = ~clk;

   lsu_vec #(.NUM_LANES(NL), .DATA_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_IDX_W(LW)) dut (
      .clk(clk), .reset(reset), .cu_state(cu_state), .lsu_en(lsu_en),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .lane_mask(lane_mask),
      .rs1(rs1), .rs2(rs2), .lsu_data_out(lsu_data_out), .lsu_state(lsu_state),
      .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
      .req_data(req_data), .req_lane(req_lane), .resp_val(resp_val),
      .resp_rdy(resp_rdy), .resp_data(resp_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input int d);
      return (d < 0) ? int'($urandom_range(0, 3)) : d;
   endfunction

   // Run one operation end to end, acting as scheduler and memory
   task automatic do_op(input vec_t v, output int cyc_o, output int nreq_o, output logic we_o);
      logic [AW-1:0]    e_addr [4];
      logic [DW-1:0]    e_data [4];
      int               e_lane [4];
      int               ecnt;
      logic             is_store;
      logic [NL*DW-1:0] mdl_dout;
      logic             fresh;
      logic [AW-1:0]    s_addr;
      logic [DW-1:0]    s_data;
      logic [LW-1:0]    s_lane;
      logic             s_we;
      int               wcnt, c, n;

      // Reference model: lanes in ascending order, loads read memory,
      // stores update memory, untouched lanes keep old results
      ecnt     = 0;
      is_store = !v.ren;
      mdl_dout = exp_dout;
      for (int i = 0; i < NL; i++) begin
         if (v.mask[i]) begin
            e_addr[ecnt] = v.r2[i*DW +: AW];
            e_data[ecnt] = v.r1[i*DW +: DW];
            e_lane[ecnt] = i;
            ecnt++;
            if (!is_store) mdl_dout[i*DW +: DW] = ref_mem[v.r2[i*DW +: AW]];
         end
      end
      if (is_store) for (int k = 0; k < ecnt; k++) ref_mem[e_addr[k]] = e_data[k];

      chk("idle_before_start", 64'(lsu_state), 64'd0);
      lsu_en = 1'b1; cu_state = 4'd3; mem_ren = v.ren; mem_wen = v.wen;
      lane_mask = v.mask; rs1 = v.r1; rs2 = v.r2;
      step();
      // Scramble the start inputs; the DUT must use its captured copies
      lsu_en = 1'($urandom); cu_state = 4'($urandom_range(0, 5));
      mem_ren = 1'($urandom); mem_wen = 1'($urandom); lane_mask = 4'($urandom);
      rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
      chk("state_after_start", 64'(lsu_state), (ecnt == 0) ? 64'd3 : 64'd1);

      fresh = 1'b1; s_we = 1'b0; s_addr = '0; s_data = '0; s_lane = '0;
      c = 0; n = 0; wcnt = pick(v.rdy_d);
      while (lsu_state != 2'd3 && c < 400) begin
         req_rdy = 1'b0; resp_val = 1'b0; resp_data = 16'($urandom);
         if (lsu_state == 2'd1) begin
            chk("req_val_in_req", 64'(req_val), 64'd1);
            chk("resp_rdy_in_req", 64'(resp_rdy), 64'd0);
            if (fresh) begin
               if (n < ecnt) begin
                  chk("req_we", 64'(req_we), 64'(is_store));
                  chk("req_addr", 64'(req_addr), 64'(e_addr[n]));
                  chk("req_data", 64'(req_data), 64'(e_data[n]));
                  chk("req_lane", 64'(req_lane), 64'(e_lane[n]));
               end else begin
                  checks++; errors++;
                  $display("FAIL extra_request: got request %0d expected only %0d", n + 1, ecnt);
               end
               s_we = req_we; s_addr = req_addr; s_data = req_data; s_lane = req_lane;
               fresh = 1'b0;
            end else begin
               chk("req_fields_stable", 64'({req_we, req_addr, req_data, req_lane}),
                   64'({s_we, s_addr, s_data, s_lane}));
            end
            if (wcnt == 0) begin
               req_rdy = 1'b1;
               wcnt = pick(v.resp_d);
            end else begin
               wcnt--;
               if (v.spur != 0) resp_val = 1'($urandom);
            end
         end else if (lsu_state == 2'd2) begin
            chk("resp_rdy_in_wait", 64'(resp_rdy), 64'd1);
            chk("req_val_in_wait", 64'(req_val), 64'd0);
            if (wcnt == 0) begin
               resp_val = 1'b1;
               if (s_we) mem[s_addr] = s_data;
               else      resp_data = mem[s_addr];
               n++; fresh = 1'b1; wcnt = pick(v.rdy_d);
            end else begin
               wcnt--;
            end
         end else begin
            checks++; errors++;
            $display("FAIL unexpected_state: got %0d expected 1..3", lsu_state);
            break;
         end
         step();
         c++;
      end
      req_rdy = 1'b0; resp_val = 1'b0;
      chk("reached_done", 64'(lsu_state), 64'd3);
      chk("num_requests", 64'(n), 64'(ecnt));
      chk("data_out", lsu_data_out, mdl_dout);
      exp_dout = mdl_dout;

      repeat ($urandom_range(0, 2)) begin
         step();
         chk("hold_done", 64'(lsu_state), 64'd3);
      end
      cu_state = 4'd6;
      step();
      chk("back_to_idle", 64'(lsu_state), 64'd0);
      cu_state = 4'd0; lsu_en = 1'b0;
      resp_val = 1'b1; resp_data = 16'($urandom);
      step();
      resp_val = 1'b0;
      chk("idle_spurious_state", 64'(lsu_state), 64'd0);
      chk("idle_spurious_dout", lsu_data_out, exp_dout);
      cyc_o = c; nreq_o = n; we_o = s_we;
   endtask

   initial begin
      reset = 1'b1; cu_state = 4'd0; lsu_en = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
      lane_mask = '0; rs1 = '0; rs2 = '0; req_rdy = 1'b0; resp_val = 1'b0; resp_data = '0;
      exp_dout = '0;
      for (int a = 0; a < 256; a++) begin
         mem[a]     = 16'(a + 100);
         ref_mem[a] = 16'(a + 100);
      end

      // {ren, wen, mask, rs1, rs2, rdy_d, resp_d, spur, exp_nreq, exp_we, exp_cyc}
      tbl[0] = '{1'b1, 1'b0, 4'hF, 64'h0, {16'd13, 16'd12, 16'd11, 16'd10}, 0, 0, 0, 4, 1'b0, 9};
      tbl[1] = '{1'b0, 1'b1, 4'hA, {16'hBBBB, 16'h0, 16'hAAAA, 16'h0},
                 {16'h30, 16'h0, 16'h20, 16'h0}, 0, 0, 0, 2, 1'b1, 5};
      tbl[2] = '{1'b1, 1'b0, 4'h0, 64'h0, 64'h0, 0, 0, 0, 0, 1'b0, 1};
      tbl[3] = '{1'b1, 1'b1, 4'h5, 64'h1111_2222_3333_4444,
                 {16'h0, 16'h41, 16'h0, 16'h40}, 0, 0, 0, 2, 1'b0, 5};
      tbl[4] = '{1'b1, 1'b0, 4'h4, 64'h0, {16'h0, 16'h20, 16'h0, 16'h0}, 3, 5, 1, 1, 1'b0, 0};
      tbl[5] = '{1'b0, 1'b1, 4'h3, 64'h0000_0000_5A5A_C3C3,
                 {16'h0, 16'h0, 16'hFF07, 16'h1206}, 2, 1, 1, 2, 1'b1, 0};

      #12;
      chk("reset_state", 64'(lsu_state), 64'd0);
      chk("reset_req_val", 64'(req_val), 64'd0);
      chk("reset_resp_rdy", 64'(resp_rdy), 64'd0);
      chk("reset_req_fields", 64'({req_we, req_addr, req_data, req_lane}), 64'd0);
      chk("reset_dout", lsu_data_out, 64'd0);
      #1 reset = 1'b0;
      step();

      // Directed table
      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i], cyc, nreq, lw);
         chk("table_nreq", 64'(nreq), 64'(tbl[i].exp_nreq));
         if (tbl[i].exp_nreq > 0) chk("table_we", 64'(lw), 64'(tbl[i].exp_we));
         if (tbl[i].exp_cyc > 0) chk("done_latency", 64'(1 + cyc), 64'(tbl[i].exp_cyc));
         if (i <= 1) chk("load4_dout", lsu_data_out, {16'd113, 16'd112, 16'd111, 16'd110});
      end

      // Reset asserted while waiting for lane 2's response
      lsu_en = 1'b1; cu_state = 4'd3; mem_ren = 1'b1; mem_wen = 1'b0; lane_mask = 4'hF;
      rs1 = '0; rs2 = {16'h3, 16'h2, 16'h1, 16'h0};
      step();
      lsu_en = 1'b0; cu_state = 4'd0;
      cyc = 0;
      while (!(lsu_state == 2'd2 && req_lane == 2'd2) && cyc < 50) begin
         req_rdy = (lsu_state == 2'd1);
         resp_val = (lsu_state == 2'd2);
         resp_data = 16'h1234 + 16'(cyc);
         step();
         cyc++;
      end
      req_rdy = 1'b0; resp_val = 1'b0;
      chk("reached_wait_lane2", 64'({lsu_state, req_lane}), 64'({2'd2, 2'd2}));
      #2 reset = 1'b1;
      #1;
      chk("abort_state", 64'(lsu_state), 64'd0);
      chk("abort_req_val", 64'(req_val), 64'd0);
      chk("abort_resp_rdy", 64'(resp_rdy), 64'd0);
      chk("abort_dout", lsu_data_out, 64'd0);
      chk("abort_req_fields", 64'({req_we, req_addr, req_data, req_lane}), 64'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      exp_dout = '0;
      step();
      rv = '{1'b1, 1'b0, 4'hF, 64'h0, {16'h30, 16'h20, 16'h41, 16'h40}, 0, 0, 0, 4, 1'b0, 9};
      do_op(rv, cyc, nreq, lw);
      chk("post_reset_latency", 64'(1 + cyc), 64'd9);
      chk("post_reset_dout", lsu_data_out, {16'hBBBB, 16'hAAAA, 16'd165, 16'd164});

      // Random operations with random backpressure and response delay
      for (int r = 0; r < 40; r++) begin
         rv.ren  = 1'($urandom);
         rv.wen  = rv.ren ? 1'($urandom) : 1'b1;
         rv.mask = 4'($urandom);
         rv.r1   = {$urandom, $urandom};
         for (int l = 0; l < NL; l++) rv.r2[l*DW +: DW] = {8'($urandom), 8'($urandom_range(0, 15))};
         rv.rdy_d = -1; rv.resp_d = -1; rv.spur = int'($urandom_range(0, 1));
         rv.exp_nreq = 0; rv.exp_we = 1'b0; rv.exp_cyc = 0;
         do_op(rv, cyc, nreq, lw);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
